// File: rtl/f32_mult_sched.sv
// f32_mult_sched: operand-pair FIFO feeding a single external FP32 multiplier.
// Pairs are queued, issued one at a time with a one-cycle mul_start pulse, and the
// product plus sticky overflow/underflow flags are held on the output until taken.
// Optional watchdog: define F32_MULT_SCHED_TIMEOUT_EN to abort a multiply that does
// not finish within TIMEOUT cycles (result 32'h7FC00000, flags 3'b100).
//
// Handshake rule (both in_* and out_* sides): a transfer happens on the rising edge
// where valid and ready are both 1; the sender holds its payload stable while valid
// is high and ready is low, and ready never depends combinationally on valid.
module f32_mult_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_p,
  input  logic        mul_ovf,
  input  logic        mul_unf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic [2:0]  out_flags,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Reject configurations the pointer/count arithmetic cannot support.
  if (DEPTH < 2 || (1 << AW) != DEPTH || TIMEOUT < 1) begin : g_bad_cfg
    $error("f32_mult_sched: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [63:0]     fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            sticky_ovf_q, sticky_unf_q;
  logic            push, pop;
  logic            wdog_expired;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign mul_start = (state_q == S_ISSUE);
  assign out_valid = (state_q == S_HOLD);
  assign dbg_state = state_q;

`ifdef F32_MULT_SCHED_TIMEOUT_EN
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [WW-1:0] wdog_q;

  assign wdog_expired = (state_q == S_WAIT) && (wdog_q == WW'(TIMEOUT - 1));

  // Watchdog: cleared when a multiply is issued, counts every cycle spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wdog_q <= '0;
    end else if (state_q == S_WAIT) begin
      wdog_q <= wdog_q + WW'(1);
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  // FIFO storage: payload only, no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one multiply in flight, done only honoured while waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mul_done || wdog_expired) state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand, sticky-flag and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a        <= '0;
      mul_b        <= '0;
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
      out_p        <= '0;
      out_flags    <= '0;
    end else begin
      if (pop) begin
        {mul_a, mul_b} <= fifo_mem[rd_ptr_q];
      end
      case (state_q)
        S_ISSUE: begin
          sticky_ovf_q <= 1'b0;
          sticky_unf_q <= 1'b0;
        end
        S_WAIT: begin
          // Flags may pulse before done, so accumulate them across the wait.
          sticky_ovf_q <= sticky_ovf_q | mul_ovf;
          sticky_unf_q <= sticky_unf_q | mul_unf;
          if (mul_done) begin
            out_p     <= mul_p;
            out_flags <= {1'b0, sticky_ovf_q | mul_ovf, sticky_unf_q | mul_unf};
          end else if (wdog_expired) begin
            out_p     <= 32'h7FC0_0000;
            out_flags <= 3'b100;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/f32_mult_sched.md
F32_MULT_SCHED -- requirements
Module: f32_mult_sched

Interface
REQ-001 Parameter DEPTH, 4, operand-queue entries; power of two, minimum 2.
REQ-002 Parameter TIMEOUT, 15, maximum cycles from mul_start to mul_done before abort (used only with the Configuration macro).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1 / in_ready  out  1 / in_a, in_b  in  32 each; upstream operand-pair handshake.
REQ-006 mul_start  out  1 / mul_a, mul_b  out  32 each; drive the multiplier's start, a and b ports.
REQ-007 mul_done  in  1 / mul_p  in  32 / mul_ovf, mul_unf  in  1 each; taken from the multiplier's done, p, overflow and underflow outputs.
REQ-008 out_valid  out  1 / out_ready  in  1 / out_p  out  32 / out_flags  out  3 ({timeout, overflow, underflow}); downstream result handshake.

Function
REQ-009 Pair accepted on the rising edge where in_valid and in_ready are both 1; written to the FIFO tail.
REQ-010 in_ready = (count < DEPTH), combinational from registered count; a simultaneous push and pop at count == DEPTH is not permitted.
REQ-011 FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-012 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-013 IDLE: if count > 0, pop the head into the operand registers (mul_a/mul_b) and go to ISSUE; otherwise stay.
REQ-014 ISSUE: mul_start = 1 for exactly this one cycle; clear the sticky flags; go to WAIT.
REQ-015 mul_a and mul_b are registered and remain stable from ISSUE until leaving WAIT.
REQ-016 WAIT: mul_ovf and mul_unf are OR-ed into sticky flags every cycle, because they pulse before mul_done.
REQ-017 WAIT with mul_done = 1: capture mul_p into out_p and {0, sticky_ovf|mul_ovf, sticky_unf|mul_unf} into out_flags; go to HOLD.
REQ-018 HOLD: out_valid = 1; out_p and out_flags stay stable until out_ready = 1, then go to IDLE.
REQ-019 mul_done outside WAIT is ignored.
REQ-020 At most one multiply in flight; results leave in acceptance order.
REQ-021 A push during IDLE-pop, ISSUE, WAIT or HOLD proceeds independently; a simultaneous push and pop leaves count unchanged.
REQ-022 Minimum throughput is one result per (multiplier latency + 3) cycles.

Reset
REQ-023 While rst = 1: state = IDLE; pointers, count and sticky flags = 0; mul_start = 0; mul_a = mul_b = 0; out_valid = 0; out_p = 0; out_flags = 0.
REQ-024 A reset asserted in WAIT or HOLD discards the in-flight operation, all queued pairs and any pending result.
REQ-025 A mul_done arriving in the first cycle after reset release is ignored (the FSM is in IDLE).

Configuration
REQ-026 Macro F32_MULT_SCHED_TIMEOUT_EN.
REQ-027 Defined: a watchdog counter resets in ISSUE and increments in WAIT; when it reaches TIMEOUT without mul_done, go to HOLD with out_p = 32'h7FC00000 and out_flags = 3'b100.
REQ-028 Undefined: no watchdog logic is present; WAIT exits only on mul_done; out_flags[2] is tied to 0.

Verification
REQ-029 Push a = 32'h40000000, b = 32'h40400000 → single mul_start pulse; after mul_done, out_valid with out_p = 32'h40C00000, out_flags = 0.
REQ-030 Multiplier pulses mul_ovf one cycle before mul_done with p = 32'h7F800000 (operands 32'h7F000000 × 2) → out_flags = 3'b010, out_p = 32'h7F800000.
REQ-031 DEPTH = 4, hold out_ready = 0, push 6 pairs back-to-back → 5 accepted (one popped into flight), then in_ready = 0; results drain in push order once out_ready = 1.
REQ-032 Assert rst for one cycle during WAIT → all outputs return to their reset values the same cycle; a later mul_done produces no out_valid.
REQ-033 With F32_MULT_SCHED_TIMEOUT_EN defined and mul_done tied to 0 → out_valid asserted with out_p = 32'h7FC00000 and out_flags = 3'b100, TIMEOUT cycles after WAIT entry.
REQ-034 Simultaneous push and pop at count = 2 → count stays at 2; the FIFO order is preserved.
